// File: rtl/as_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package as_pack;

  // Controller sequencing states (memory handshake tracking).
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hazard_state_t;

  // ALU operand source select.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  // Default number of MEM_WAIT cycles tolerated before flagging a timeout.
  localparam int MEM_TIMEOUT_DFLT = 255;

endpackage

// File: rtl/as_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The master side is the pipeline, the slave side is the controller.
interface as_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  import as_pack::*;

  logic [REG_ADDR_W-1:0] id_rs1_i, id_rs2_i;
  logic                  id_use_rs1_i, id_use_rs2_i;
  logic [REG_ADDR_W-1:0] ex_rs1_i, ex_rs2_i, ex_rd_i;
  logic                  ex_is_load_i, ex_branch_taken_i;
  logic [REG_ADDR_W-1:0] mem_rd_i;
  logic                  mem_reg_wr_i;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic                  wb_reg_wr_i;
  logic                  dmem_req_i, dmem_ready_i;

  fwd_sel_t              forward_a_o, forward_b_o;
  logic                  stall_if_o, stall_id_o;
  logic                  flush_id_o, flush_ex_o;
  logic                  freeze_o, timeout_o;
  logic [CNT_W-1:0]      stall_cnt_o, flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, ex_is_load_i, ex_branch_taken_i,
           mem_rd_i, mem_reg_wr_i, wb_rd_i, wb_reg_wr_i,
           dmem_req_i, dmem_ready_i,
    input  forward_a_o, forward_b_o, stall_if_o, stall_id_o,
           flush_id_o, flush_ex_o, freeze_o, timeout_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, ex_is_load_i, ex_branch_taken_i,
           mem_rd_i, mem_reg_wr_i, wb_rd_i, wb_reg_wr_i,
           dmem_req_i, dmem_ready_i,
    output forward_a_o, forward_b_o, stall_if_o, stall_id_o,
           flush_id_o, flush_ex_o, freeze_o, timeout_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/as_hazard_ctrl_fwd_unit.sv
// Forwarding select for one ALU operand; the MEM-stage result is newer than
// the WB-stage result, so a MEM match wins. x0 is never forwarded.
module as_fwd_unit
  import as_pack::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_wr,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_wr,
  output fwd_sel_t              o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_reg_wr && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs);
  assign w_wb_hit  = i_wb_reg_wr  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_rs);

  // Prioritised source selection: MEM, then WB, else register file.
  always_comb begin
    o_sel = FWD_REG;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/as_hazard_ctrl.sv
// Central hazard controller: forwarding, load-use stall, branch flush,
// data-memory freeze with timeout, and saturating debug event counters.
//
// state    | meaning
// RUN      | normal flow, hazards resolved by stall/flush
// MEM_WAIT | data access outstanding, pipeline frozen until ready
// TIMEOUT  | access never completed, frozen with sticky error until reset
module as_hazard_ctrl
  import as_pack::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DFLT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  as_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hazard_state_t     r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  fwd_sel_t w_fwd_a, w_fwd_b;
  logic     w_lu, w_freeze, w_active, w_stall_eff, w_flush_eff;

  as_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_ex_rs      (hz.ex_rs1_i),
    .i_mem_rd     (hz.mem_rd_i),
    .i_mem_reg_wr (hz.mem_reg_wr_i),
    .i_wb_rd      (hz.wb_rd_i),
    .i_wb_reg_wr  (hz.wb_reg_wr_i),
    .o_sel        (w_fwd_a)
  );

  as_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_ex_rs      (hz.ex_rs2_i),
    .i_mem_rd     (hz.mem_rd_i),
    .i_mem_reg_wr (hz.mem_reg_wr_i),
    .i_wb_rd      (hz.wb_rd_i),
    .i_wb_reg_wr  (hz.wb_reg_wr_i),
    .o_sel        (w_fwd_b)
  );

  assign w_lu = hz.ex_is_load_i && (hz.ex_rd_i != '0) &&
                ((hz.id_use_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                 (hz.id_use_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));

  // Freeze is combinational so the pipeline holds in the very cycle the
  // access stalls and releases in the very cycle ready arrives.
  always_comb begin
    w_freeze = 1'b0;
    case (r_state)
      RUN:      w_freeze = hz.dmem_req_i && !hz.dmem_ready_i;
      MEM_WAIT: w_freeze = !hz.dmem_ready_i;
      TIMEOUT:  w_freeze = 1'b1;
      default:  w_freeze = 1'b0;
    endcase
    if (!rst_i) w_freeze = 1'b0;
  end

  // Stall/flush only act in RUN with no freeze; the MEM_WAIT release cycle
  // stays quiet too. Branch flush outranks load-use.
  assign w_active    = rst_i && (r_state == RUN) && !w_freeze;
  assign w_flush_eff = w_active && hz.ex_branch_taken_i;
  assign w_stall_eff = w_active && w_lu && !hz.ex_branch_taken_i;

  assign hz.forward_a_o = rst_i ? w_fwd_a : FWD_REG;
  assign hz.forward_b_o = rst_i ? w_fwd_b : FWD_REG;
  assign hz.stall_if_o  = w_stall_eff;
  assign hz.stall_id_o  = w_stall_eff;
  assign hz.flush_id_o  = w_flush_eff;
  assign hz.flush_ex_o  = w_flush_eff || w_stall_eff;
  assign hz.freeze_o    = w_freeze;
  assign hz.timeout_o   = r_timeout;
  assign hz.stall_cnt_o = r_stall_cnt;
  assign hz.flush_cnt_o = r_flush_cnt;

  // Memory handshake FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (hz.dmem_req_i && !hz.dmem_ready_i) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.dmem_ready_i) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            r_state    <= TIMEOUT;
            r_wait_cnt <= WAIT_W'(MEM_TIMEOUT);
            r_timeout  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        TIMEOUT: begin
          r_state   <= TIMEOUT;
          r_timeout <= 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Saturating debug counters of effective stall and flush events.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_eff && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_eff && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_as_hazard_ctrl.sv
// Bench for as_hazard_ctrl: directed per-cycle vectors with expected outputs
// queued by the driver and checked by an independent monitor.
module tb_as_hazard_ctrl;
  import as_pack::*;

  localparam int TMO = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  as_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hz();

  as_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16), .MEM_TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (hz)
  );

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       use1, use2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ld, br;
    logic [4:0] mem_rd;
    logic       mem_wr;
    logic [4:0] wb_rd;
    logic       wb_wr;
    logic       req, rdy;
  } in_t;

  typedef struct {
    string nm;
    int fa, fb, stall, flush_id, flush_ex, freeze, tmo, scnt, fcnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic exp_t ex(string nm, int fa, int fb, int stall, int fid,
                              int fex, int frz, int tmo, int s, int f);
    exp_t e;
    e.nm = nm; e.fa = fa; e.fb = fb; e.stall = stall; e.flush_id = fid;
    e.flush_ex = fex; e.freeze = frz; e.tmo = tmo; e.scnt = s; e.fcnt = f;
    return e;
  endfunction

  task automatic drive(in_t v);
    hz.id_rs1_i = v.id_rs1;  hz.id_rs2_i = v.id_rs2;
    hz.id_use_rs1_i = v.use1; hz.id_use_rs2_i = v.use2;
    hz.ex_rs1_i = v.ex_rs1;  hz.ex_rs2_i = v.ex_rs2; hz.ex_rd_i = v.ex_rd;
    hz.ex_is_load_i = v.ld;  hz.ex_branch_taken_i = v.br;
    hz.mem_rd_i = v.mem_rd;  hz.mem_reg_wr_i = v.mem_wr;
    hz.wb_rd_i = v.wb_rd;    hz.wb_reg_wr_i = v.wb_wr;
    hz.dmem_req_i = v.req;   hz.dmem_ready_i = v.rdy;
  endtask

  // One pipeline cycle: inputs applied just after the edge, expectation queued.
  task automatic step(in_t v, exp_t e);
    @(posedge clk);
    #1;
    drive(v);
    q.push_back(e);
  endtask

  // Monitor: every cycle with a pending expectation, compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, "/fwd_a"},    int'(hz.forward_a_o), e.fa);
        chk({e.nm, "/fwd_b"},    int'(hz.forward_b_o), e.fb);
        chk({e.nm, "/stall_if"}, int'(hz.stall_if_o),  e.stall);
        chk({e.nm, "/stall_id"}, int'(hz.stall_id_o),  e.stall);
        chk({e.nm, "/flush_id"}, int'(hz.flush_id_o),  e.flush_id);
        chk({e.nm, "/flush_ex"}, int'(hz.flush_ex_o),  e.flush_ex);
        chk({e.nm, "/freeze"},   int'(hz.freeze_o),    e.freeze);
        chk({e.nm, "/timeout"},  int'(hz.timeout_o),   e.tmo);
        chk({e.nm, "/stall_cnt"}, int'(hz.stall_cnt_o), e.scnt);
        chk({e.nm, "/flush_cnt"}, int'(hz.flush_cnt_o), e.fcnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_all_zero(string nm);
    chk({nm, "/fwd_a"},    int'(hz.forward_a_o), 0);
    chk({nm, "/fwd_b"},    int'(hz.forward_b_o), 0);
    chk({nm, "/stall_if"}, int'(hz.stall_if_o),  0);
    chk({nm, "/flush_ex"}, int'(hz.flush_ex_o),  0);
    chk({nm, "/flush_id"}, int'(hz.flush_id_o),  0);
    chk({nm, "/freeze"},   int'(hz.freeze_o),    0);
    chk({nm, "/timeout"},  int'(hz.timeout_o),   0);
    chk({nm, "/stall_cnt"}, int'(hz.stall_cnt_o), 0);
    chk({nm, "/flush_cnt"}, int'(hz.flush_cnt_o), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: actual=%0d pending expected=0 pending", q.size());
    end
  endtask

  initial begin
    in_t v;

    // Hazard-looking inputs while held in reset: every output must read 0.
    v = idle();
    v.ex_rs1 = 5'd7; v.mem_rd = 5'd7; v.mem_wr = 1'b1;
    v.ld = 1'b1; v.ex_rd = 5'd3; v.id_rs1 = 5'd3; v.use1 = 1'b1;
    v.br = 1'b1; v.req = 1'b1;
    drive(v);
    #12;
    check_all_zero("in_reset");
    drive(idle());
    @(negedge clk);
    rst_n = 1'b1;

    // add x7,x4,x5 ; add x8,x7,x6 ; sub x3,x9,x7  (x4=5,x5=6,x6=7,x9=12)
    v = idle(); v.ex_rs1 = 5'd7; v.ex_rs2 = 5'd6; v.mem_rd = 5'd7; v.mem_wr = 1'b1;
    v.id_rs1 = 5'd9; v.id_rs2 = 5'd7; v.use1 = 1'b1; v.use2 = 1'b1;
    step(v, ex("chain_add2", 2, 0, 0, 0, 0, 0, 0, 0, 0));
    v = idle(); v.ex_rs1 = 5'd9; v.ex_rs2 = 5'd7; v.mem_rd = 5'd8; v.mem_wr = 1'b1;
    v.wb_rd = 5'd7; v.wb_wr = 1'b1;
    step(v, ex("chain_sub", 0, 1, 0, 0, 0, 0, 0, 0, 0));
    v = idle(); v.ex_rs1 = 5'd5; v.ex_rs2 = 5'd5; v.mem_rd = 5'd5; v.mem_wr = 1'b1;
    v.wb_rd = 5'd5; v.wb_wr = 1'b1;
    step(v, ex("mem_over_wb", 2, 2, 0, 0, 0, 0, 0, 0, 0));
    v = idle(); v.ex_rs1 = 5'd3; v.ex_rs2 = 5'd4; v.mem_rd = 5'd3; v.mem_wr = 1'b0;
    v.wb_rd = 5'd4; v.wb_wr = 1'b1;
    step(v, ex("mem_no_wr", 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // ld x5,0(x2) ; add x6,x5,x1
    v = idle(); v.ld = 1'b1; v.ex_rd = 5'd5; v.ex_rs1 = 5'd2;
    v.id_rs1 = 5'd5; v.id_rs2 = 5'd1; v.use1 = 1'b1; v.use2 = 1'b1;
    step(v, ex("lu_stall", 0, 0, 1, 0, 1, 0, 0, 0, 0));
    v = idle(); v.mem_rd = 5'd5; v.mem_wr = 1'b1;
    step(v, ex("lu_bubble", 0, 0, 0, 0, 0, 0, 0, 1, 0));
    v = idle(); v.ex_rs1 = 5'd5; v.ex_rs2 = 5'd1; v.wb_rd = 5'd5; v.wb_wr = 1'b1;
    step(v, ex("lu_fwd_wb", 1, 0, 0, 0, 0, 0, 0, 1, 0));

    v = idle(); v.ld = 1'b1; v.ex_rd = 5'd0; v.id_rs1 = 5'd0; v.use1 = 1'b1;
    step(v, ex("lu_x0", 0, 0, 0, 0, 0, 0, 0, 1, 0));
    v = idle(); v.ld = 1'b1; v.ex_rd = 5'd6; v.id_rs1 = 5'd6; v.use1 = 1'b0;
    v.id_rs2 = 5'd2; v.use2 = 1'b1;
    step(v, ex("lu_unused_rs1", 0, 0, 0, 0, 0, 0, 0, 1, 0));
    v = idle(); v.ld = 1'b1; v.ex_rd = 5'd6; v.id_rs1 = 5'd6; v.use1 = 1'b0;
    v.id_rs2 = 5'd6; v.use2 = 1'b1;
    step(v, ex("lu_rs2", 0, 0, 1, 0, 1, 0, 0, 1, 0));
    step(idle(), ex("idle1", 0, 0, 0, 0, 0, 0, 0, 2, 0));

    // Taken beq with a simultaneous load-use condition.
    v = idle(); v.br = 1'b1; v.ld = 1'b1; v.ex_rd = 5'd4; v.id_rs1 = 5'd4; v.use1 = 1'b1;
    step(v, ex("branch_lu", 0, 0, 0, 1, 1, 0, 0, 2, 0));
    step(idle(), ex("idle2", 0, 0, 0, 0, 0, 0, 0, 2, 1));

    // Write x0 then read x0.
    v = idle(); v.mem_rd = 5'd0; v.mem_wr = 1'b1; v.wb_rd = 5'd0; v.wb_wr = 1'b1;
    step(v, ex("x0_fwd", 0, 0, 0, 0, 0, 0, 0, 2, 1));

    // Store with ready low 3 cycles; hazards present but suppressed.
    v = idle(); v.req = 1'b1; v.br = 1'b1; v.ld = 1'b1; v.ex_rd = 5'd4;
    v.id_rs1 = 5'd4; v.use1 = 1'b1; v.ex_rs1 = 5'd7; v.mem_rd = 5'd7; v.mem_wr = 1'b1;
    step(v, ex("st_wait0", 2, 0, 0, 0, 0, 1, 0, 2, 1));
    step(v, ex("st_wait1", 2, 0, 0, 0, 0, 1, 0, 2, 1));
    step(v, ex("st_wait2", 2, 0, 0, 0, 0, 1, 0, 2, 1));
    v = idle(); v.req = 1'b1; v.rdy = 1'b1;
    step(v, ex("st_ready", 0, 0, 0, 0, 0, 0, 0, 2, 1));
    step(idle(), ex("st_after", 0, 0, 0, 0, 0, 0, 0, 2, 1));
    v = idle(); v.req = 1'b1; v.rdy = 1'b1;
    step(v, ex("st_immediate", 0, 0, 0, 0, 0, 0, 0, 2, 1));

    // Ready held low for TMO+2 cycles: timeout raised on the last one.
    for (int i = 0; i <= TMO + 1; i++) begin
      v = idle(); v.req = 1'b1;
      step(v, ex("tmo_wait", 0, 0, 0, 0, 0, 1, (i >= TMO + 1) ? 1 : 0, 2, 1));
    end
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.rdy = 1'b1;
      step(v, ex("tmo_sticky", 0, 0, 0, 0, 0, 1, 1, 2, 1));
    end
    drain();

    // Asynchronous reset mid-cycle clears the timeout and returns to RUN.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #3;
    rst_n = 1'b1;
    step(idle(), ex("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v = idle(); v.ld = 1'b1; v.ex_rd = 5'd9; v.id_rs2 = 5'd9; v.use2 = 1'b1;
    step(v, ex("post_rst_lu", 0, 0, 1, 0, 1, 0, 0, 0, 0));
    v = idle(); v.req = 1'b1;
    step(v, ex("post_rst_req", 0, 0, 0, 0, 0, 1, 0, 1, 0));
    v = idle(); v.req = 1'b1; v.rdy = 1'b1;
    step(v, ex("post_rst_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(idle(), ex("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
